hamming_batch_ctrl: RTL and testbench

Batch controller that sequences the shared `HAMMING_IP` single-error-correcting decoder. It accepts `DEPTH` codewords through a valid/ready input port and decodes each one through a single decoder instance on the cycle it is accepted. It stores the corrected data words with a per-word "data corrected" flag, then drains the batch in arrival order through a valid/ready output port with backpressure. It sits between the pattern input stage and the downstream compute stage that consumes corrected operands.

---
 rtl/hamming_batch_ctrl_pkg.sv | 18 +
 rtl/hamming_batch_ctrl_ip.sv | 32 +++
 rtl/hamming_batch_ctrl.sv | 107 ++++++++++
 tb/tb_hamming_batch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_batch_ctrl_pkg.sv
// Shared types and codeword layout for the Hamming batch controller.
// Codeword positions are 1-based; position p sits at bit (IP_BIT+4-p).
package hamming_batch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  localparam int NUM_PAR = 4;
  localparam int PAR_POS [NUM_PAR] = '{1, 2, 4, 8};

  // Data bit k (k=0 is the data MSB) lives at DATA_POS[k]; supports IP_BIT up to 11.
  localparam int MAX_DATA = 11;
  localparam int DATA_POS [MAX_DATA] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/hamming_batch_ctrl_ip.sv
// Combinational single-error-correcting Hamming decoder (HAMMING_IP).
// Syndromes beyond the codeword length leave the data untouched.
module HAMMING_IP
  import hamming_batch_ctrl_pkg::*;
#(
  parameter int IP_BIT = 8
) (
  input  logic [IP_BIT+3:0] i_code,
  output logic [IP_BIT-1:0] o_data
);

  localparam int CW = IP_BIT + 4;

  logic [3:0]    w_syn;
  logic [CW-1:0] w_fixed_code;

  always_comb begin
    w_syn        = '0;
    w_fixed_code = i_code;
    o_data       = '0;
    for (int p = 1; p <= CW; p++) begin
      if (i_code[CW-p]) w_syn = w_syn ^ 4'(p);
    end
    for (int p = 1; p <= CW; p++) begin
      if (int'(w_syn) == p) w_fixed_code[CW-p] = ~i_code[CW-p];
    end
    for (int k = 0; k < IP_BIT; k++) begin
      o_data[IP_BIT-1-k] = w_fixed_code[CW-DATA_POS[k]];
    end
  end

endmodule

// File: rtl/hamming_batch_ctrl.sv
// Collects DEPTH codewords, decodes each on accept through one shared decoder,
// then drains the corrected words in arrival order with valid/ready backpressure.
module hamming_batch_ctrl
  import hamming_batch_ctrl_pkg::*;
#(
  parameter int IP_BIT = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IP_BIT+3:0]          in_code,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IP_BIT-1:0]          out_code,
  output logic                       out_fixed,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] fix_cnt,
  output state_t                     o_dbg_state
);

  // Handshake: a beat moves on a rising edge where valid & ready are both high;
  // valid never waits on ready, and the sender holds its payload until the beat moves.

  localparam int CW = IP_BIT + 4;
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  state_t              r_state;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [FW-1:0]       r_fix_cnt;
  logic [IP_BIT-1:0]   r_buf_data [DEPTH];
  logic [DEPTH-1:0]    r_buf_fix;

  logic [IP_BIT-1:0]   w_dec_data;
  logic [IP_BIT-1:0]   w_raw_data;
  logic                w_fix;
  logic                w_accept;

  HAMMING_IP #(.IP_BIT(IP_BIT)) u_dec (
    .i_code (in_code),
    .o_data (w_dec_data)
  );

  // Raw data bits straight from the codeword, to detect whether correction touched data.
  always_comb begin
    w_raw_data = '0;
    for (int k = 0; k < IP_BIT; k++) begin
      w_raw_data[IP_BIT-1-k] = in_code[CW-DATA_POS[k]];
    end
  end

  assign w_fix       = (w_raw_data != w_dec_data);
  assign in_ready    = (r_state != S_DRAIN);
  assign w_accept    = in_valid & in_ready;
  assign out_valid   = (r_state == S_DRAIN);
  assign out_code    = r_buf_data[r_rd_ptr];
  assign out_fixed   = r_buf_fix[r_rd_ptr];
  assign out_last    = (r_rd_ptr == PW'(DEPTH - 1));
  assign fix_cnt     = r_fix_cnt;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fix_cnt <= '0;
      r_buf_fix <= '0;
      for (int i = 0; i < DEPTH; i++) r_buf_data[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (w_accept) begin
            r_buf_data[r_wr_ptr] <= w_dec_data;
            r_buf_fix[r_wr_ptr]  <= w_fix;
            r_fix_cnt            <= r_fix_cnt + FW'(w_fix);
            if (r_wr_ptr == PW'(DEPTH - 1)) begin
              r_wr_ptr <= '0;
              r_state  <= S_DRAIN;
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              r_state  <= S_COLLECT;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_rd_ptr == PW'(DEPTH - 1)) begin
              r_rd_ptr  <= '0;
              r_wr_ptr  <= '0;
              r_fix_cnt <= '0;
              r_buf_fix <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_rd_ptr <= r_rd_ptr + PW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_batch_ctrl.sv
// Randomized scoreboard bench for hamming_batch_ctrl: words are built by encoding
// known data and optionally flipping one position, so the expected output is the data itself.
module tb_hamming_batch_ctrl;
  import hamming_batch_ctrl_pkg::*;

  localparam int IP_BIT = 8;
  localparam int DEPTH  = 4;
  localparam int CW     = IP_BIT + 4;
  localparam int FW     = $clog2(DEPTH + 1);
  localparam int EW     = IP_BIT + 2 + FW;

  logic              clk = 0;
  logic              rst_n = 0;
  logic              in_valid = 0;
  logic              in_ready;
  logic [CW-1:0]     in_code = '0;
  logic              out_valid;
  logic              out_ready = 1;
  logic [IP_BIT-1:0] out_code;
  logic              out_fixed;
  logic              out_last;
  logic [FW-1:0]     fix_cnt;
  state_t            dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_mode  = 0;  // 0: ready high, 1: random ready, 2: ready held low

  logic [EW-1:0]     exp_q [$];
  logic [IP_BIT:0]   pend [$];

  hamming_batch_ctrl #(.IP_BIT(IP_BIT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_fixed(out_fixed), .out_last(out_last),
    .fix_cnt(fix_cnt), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got timeout, expected event at %0t", name, $time);
  endtask

  function automatic logic [CW-1:0] encode(input logic [IP_BIT-1:0] d);
    logic [CW-1:0] c;
    logic          par;
    int            k;
    c = '0;
    k = 0;
    for (int p = 1; p <= CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[CW-p] = d[IP_BIT-1-k];
        k++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      par = 1'b0;
      for (int p = 1; p <= CW; p++) begin
        if (((p >> i) & 1) == 1 && p != (1 << i)) par = par ^ c[CW-p];
      end
      c[CW-(1 << i)] = par;
    end
    return c;
  endfunction

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #2;
    if (bp_mode == 2)      out_ready = 1'b0;
    else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else                   out_ready = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [CW-1:0] code, input logic [IP_BIT-1:0] data,
                           input logic fixed, input int gap);
    bit   done;
    int   cnt;
    logic [EW-1:0] e;
    done     = 0;
    in_valid = 1'b1;
    in_code  = code;
    for (int t = 0; t < 300 && !done; t++) begin
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      fail_now("accept_timeout");
      return;
    end
    pend.push_back({data, fixed});
    if (pend.size() == DEPTH) begin
      check("drain_latency", out_valid, 1);
      cnt = 0;
      foreach (pend[i]) if (pend[i][0]) cnt++;
      foreach (pend[i]) begin
        e = {pend[i][IP_BIT:1], pend[i][0], (i == DEPTH - 1) ? 1'b1 : 1'b0, FW'(cnt)};
        exp_q.push_back(e);
      end
      pend.delete();
    end else begin
      check("collect_no_valid", out_valid, 0);
    end
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rand(input int gap);
    logic [IP_BIT-1:0] d;
    logic [CW-1:0]     c;
    int                ep;
    d  = IP_BIT'($urandom);
    ep = $urandom_range(0, CW);
    c  = encode(d);
    if (ep != 0) c[CW-ep] = ~c[CW-ep];
    send_word(c, d, (ep != 0) && ((ep & (ep - 1)) != 0), gap);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) fail_now("drain_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_code"},  out_code, 0);
    check({tag, "_out_fixed"}, out_fixed, 0);
    check({tag, "_out_last"},  out_last, 0);
    check({tag, "_fix_cnt"},   fix_cnt, 0);
    check({tag, "_in_ready"},  in_ready, 1);
    check({tag, "_state"},     dbg_state, S_IDLE);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] held;
  bit            held_valid = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] cur;
    if (!rst_n) begin
      held_valid = 0;
    end else begin
      cur = {out_code, out_fixed, out_last, fix_cnt};
      check("in_ready_vs_drain", in_ready, !out_valid);
      if (out_valid) begin
        if (held_valid) check("stall_hold", cur, held);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("out_code",  out_code,  e[EW-1 -: IP_BIT]);
          check("out_fixed", out_fixed, e[FW+1]);
          check("out_last",  out_last,  e[FW]);
          check("fix_cnt",   fix_cnt,   e[FW-1:0]);
          held_valid = 0;
        end else begin
          held       = cur;
          held_valid = 1;
        end
      end else begin
        held_valid = 0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // clean batch
    for (int i = 0; i < DEPTH; i++) send_word(12'hE45, 8'hA5, 1'b0, 0);
    wait_drain();

    // data error at position 6 in word 0
    send_word(12'hE05, 8'hA5, 1'b1, 0);
    for (int i = 1; i < DEPTH; i++) send_word(12'hE45, 8'hA5, 1'b0, 0);
    wait_drain();

    // parity-only error at position 4
    for (int i = 0; i < DEPTH; i++) send_word(12'hF45, 8'hA5, 1'b0, 0);
    wait_drain();

    // backpressure for 3 drain cycles with dropped in_valid pulses
    bp_mode = 2;
    for (int i = 0; i < DEPTH; i++) send_word(12'hE45, 8'hA5, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_code  = CW'($urandom);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_code", out_code, 8'hA5);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    bp_mode  = 0;
    wait_drain();

    // gapped input
    for (int i = 0; i < DEPTH; i++) send_rand(1);
    wait_drain();

    // reset mid-COLLECT after 2 accepts
    send_rand(0);
    send_rand(0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midreset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) send_rand(0);
    wait_drain();

    // random back-to-back batches with random backpressure and gaps
    bp_mode = 1;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < DEPTH; i++) send_rand($urandom_range(0, 2));
    end
    wait_drain();
    bp_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
